// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the data-RAM port arbiter
package mem_arb_pkg;

    localparam int         NUM_WAYS   = 2;
    localparam logic [2:0] WRITE_DONE = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [3:0]  wmask;
        logic [1:0]  pID;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - per-way request/response and RAM port bundle
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic [NUM_WAYS-1:0]       req_valid_i;
    logic [NUM_WAYS-1:0]       req_we_i;
    logic [NUM_WAYS-1:0][31:0] req_addr_i;
    logic [NUM_WAYS-1:0][63:0] req_wdata_i;
    logic [NUM_WAYS-1:0][3:0]  req_wmask_i;
    logic [NUM_WAYS-1:0][1:0]  req_pID_i;
    logic [NUM_WAYS-1:0]       req_ready_o;
    logic [NUM_WAYS-1:0]       resp_valid_o;
    logic [63:0]               resp_rdata_o;
    logic                      resp_err_o;
    logic [1:0]                resp_pID_o;
    logic [31:0]               readAddr_o;
    logic [31:0]               writeAddr_o;
    logic [63:0]               writeData_o;
    logic [3:0]                writeMask_o;
    logic [63:0]               readData_i;
    logic                      dataOk_i;
    logic [2:0]                writeState_i;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wmask_i, req_pID_i,
        input  readData_i, dataOk_i, writeState_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, resp_pID_o,
        output readAddr_o, writeAddr_o, writeData_o, writeMask_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wmask_i, req_pID_i,
        output readData_i, dataOk_i, writeState_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, resp_pID_o,
        input  readAddr_o, writeAddr_o, writeData_o, writeMask_o
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// rtl/mem_port_arbiter_rr_arbiter2.sv - two-way round-robin grant with last-grant memory
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant,
    output logic       o_grant_idx
);

    logic r_last_grant;
    logic w_idx;

    always_comb begin
        w_idx = 1'b0;
        case (i_req)
            2'b10:   w_idx = 1'b1;
            2'b11:   w_idx = ~r_last_grant;
            default: w_idx = 1'b0;
        endcase
    end

    assign o_grant_idx = w_idx;
    assign o_grant     = (i_req == 2'b00) ? 2'b00 : (w_idx ? 2'b10 : 2'b01);

    // Reset to way1 so that way0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
        end else if (|i_req) begin
            r_last_grant <= w_idx;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one data-RAM port between two ways; MEM_ARB_PERF_EN adds perf counters
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0] perf_accesses_o,
    output logic [31:0] perf_conflicts_o,
    output logic [15:0] perf_timeouts_o,
`endif
    mem_port_arbiter_if.slave bus
);

    localparam int             CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    arb_state_e    r_state;
    logic          r_gidx;
    logic [1:0]    r_pid;
    logic [CW-1:0] r_cnt;

    logic [1:0]    w_req;
    logic [1:0]    w_grant;
    logic          w_gidx;
    logic          w_accept;
    logic          w_done;
    logic          w_timeout;
    mem_req_t      w_sel;

    assign w_req    = bus.req_valid_i & {2{r_state == IDLE}};
    assign w_accept = |w_req;

    rr_arbiter2 u_rr (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_req      (w_req),
        .o_grant    (w_grant),
        .o_grant_idx(w_gidx)
    );

    assign bus.req_ready_o = w_grant;

    always_comb begin
        w_sel.we    = bus.req_we_i[w_gidx];
        w_sel.addr  = bus.req_addr_i[w_gidx];
        w_sel.wdata = bus.req_wdata_i[w_gidx];
        w_sel.wmask = bus.req_wmask_i[w_gidx];
        w_sel.pID   = bus.req_pID_i[w_gidx];
    end

    // Completion in the last counted cycle takes priority over the timeout.
    assign w_done    = ((r_state == RD_WAIT) && bus.dataOk_i) ||
                       ((r_state == WR_WAIT) && (bus.writeState_i == WRITE_DONE));
    assign w_timeout = (r_state != IDLE) && !w_done && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= IDLE;
            r_gidx           <= 1'b0;
            r_pid            <= 2'd0;
            r_cnt            <= '0;
            bus.readAddr_o   <= '0;
            bus.writeAddr_o  <= '0;
            bus.writeData_o  <= '0;
            bus.writeMask_o  <= '0;
            bus.resp_valid_o <= '0;
            bus.resp_rdata_o <= '0;
            bus.resp_err_o   <= 1'b0;
            bus.resp_pID_o   <= 2'd0;
        end else begin
            bus.resp_valid_o <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_gidx <= w_gidx;
                        r_pid  <= w_sel.pID;
                        r_cnt  <= '0;
                        if (w_sel.we) begin
                            r_state         <= WR_WAIT;
                            bus.writeAddr_o <= w_sel.addr;
                            bus.writeData_o <= w_sel.wdata;
                            bus.writeMask_o <= w_sel.wmask;
                        end else begin
                            r_state        <= RD_WAIT;
                            bus.readAddr_o <= w_sel.addr;
                        end
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (w_done || w_timeout) begin
                        r_state          <= IDLE;
                        bus.readAddr_o   <= '0;
                        bus.writeAddr_o  <= '0;
                        bus.writeData_o  <= '0;
                        bus.writeMask_o  <= '0;
                        bus.resp_valid_o <= r_gidx ? 2'b10 : 2'b01;
                        bus.resp_pID_o   <= r_pid;
                        bus.resp_err_o   <= w_timeout;
                        bus.resp_rdata_o <= (w_done && (r_state == RD_WAIT)) ? bus.readData_i : 64'd0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_perf_acc;
    logic [31:0] r_perf_conf;
    logic [15:0] r_perf_tmo;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_acc  <= '0;
            r_perf_conf <= '0;
            r_perf_tmo  <= '0;
        end else begin
            if (w_accept && (r_perf_acc != '1)) r_perf_acc <= r_perf_acc + 32'd1;
            if ((w_req == 2'b11) && (r_perf_conf != '1)) r_perf_conf <= r_perf_conf + 32'd1;
            if (w_timeout && (r_perf_tmo != '1)) r_perf_tmo <= r_perf_tmo + 16'd1;
        end
    end

    assign perf_accesses_o  = r_perf_acc;
    assign perf_conflicts_o = r_perf_conf;
    assign perf_timeouts_o  = r_perf_tmo;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench with a behavioural RAM and arbitration model
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int TMO = 8;

    typedef struct packed {
        logic [1:0]  pid;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_acc;
    logic [31:0] perf_conf;
    logic [15:0] perf_tmo;
`endif

    mem_port_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
`ifdef MEM_ARB_PERF_EN
        .perf_accesses_o (perf_acc),
        .perf_conflicts_o(perf_conf),
        .perf_timeouts_o (perf_tmo),
`endif
        .bus             (bus)
    );

    int       passed = 0, total = 0;
    mem_req_t pend[2][$];
    exp_t     exp_q[2][$];
    bit       pop[2];
    bit       mon_en = 0, gen_en = 0, ram_en = 1;
    int       force_d = -1;
    bit       inflight = 0;
    int       age = 0, done_age = -100, infl_way = 0, tb_last = 1;
    mem_req_t infl;
    bit       ram_active = 0;
    int       ram_cnt = 0, ram_d = 0;
    int       n_acc = 0, n_conf = 0, n_tmo = 0;

    function automatic logic [63:0] ram_word(input logic [31:0] a);
        if (a == 32'h8000_1000) return 64'hDEADBEEF_12345678;
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    function automatic mem_req_t mk_req(input logic we, input logic [31:0] a, input logic [63:0] d,
                                        input logic [3:0] m, input logic [1:0] p);
        mem_req_t r;
        r.we = we; r.addr = a; r.wdata = d; r.wmask = m; r.pID = p;
        return r;
    endfunction

    function automatic mem_req_t rand_req();
        logic [31:0] a;
        a = ($urandom_range(0, 7) == 0) ? 32'h0 : (32'h8000_0000 | $urandom);
        return mk_req(1'($urandom), a, {$urandom, $urandom}, 4'($urandom), 2'($urandom));
    endfunction

    // Expected response follows from the request alone: address 0 never completes.
    task automatic push_req(input int w, input mem_req_t r);
        exp_t e;
        e.pid = r.pID;
        if (r.addr == 32'h0) begin e.rdata = 64'h0; e.err = 1'b1; end
        else if (r.we)       begin e.rdata = 64'h0; e.err = 1'b0; end
        else                 begin e.rdata = ram_word(r.addr); e.err = 1'b0; end
        pend[w].push_back(r);
        exp_q[w].push_back(e);
    endtask

    task automatic drive_inputs();
        for (int w = 0; w < 2; w++) begin
            if (pend[w].size() > 0) begin
                bus.req_valid_i[w] = 1'b1;
                bus.req_we_i[w]    = pend[w][0].we;
                bus.req_addr_i[w]  = pend[w][0].addr;
                bus.req_wdata_i[w] = pend[w][0].wdata;
                bus.req_wmask_i[w] = pend[w][0].wmask;
                bus.req_pID_i[w]   = pend[w][0].pID;
            end else begin
                bus.req_valid_i[w] = 1'b0;
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int w = 0; w < 2; w++) begin
            if (pop[w]) begin
                pop[w] = 1'b0;
                if (pend[w].size() > 0) void'(pend[w].pop_front());
            end
            if (gen_en && pend[w].size() < 2 && $urandom_range(0, 99) < 30) push_req(w, rand_req());
        end
        drive_inputs();
    end

    always @(negedge clk) begin
        int          w, g;
        logic [1:0]  vld, expr;
        exp_t        e;
        logic [31:0] er, ew;
        logic [63:0] ed;
        logic [3:0]  em;
        if (mon_en) begin
            if (inflight) age++;
            if (bus.resp_valid_o != 2'b00) begin
                chk("resp_onehot", 160'($onehot(bus.resp_valid_o)), 1);
                w = bus.resp_valid_o[1] ? 1 : 0;
                chk("resp_way", w, infl_way);
                if (exp_q[w].size() == 0) begin
                    chk("resp_unexpected", 1, 0);
                end else begin
                    e = exp_q[w].pop_front();
                    chk("resp_pid", bus.resp_pID_o, e.pid);
                    chk("resp_rdata", bus.resp_rdata_o, e.rdata);
                    chk("resp_err", bus.resp_err_o, e.err);
                    chk("resp_latency", age, e.err ? TMO + 1 : done_age + 1);
                    if (e.err) n_tmo++;
                end
                inflight = 1'b0;
            end
            er = '0; ew = '0; ed = '0; em = '0;
            if (inflight && age >= 1) begin
                if (infl.we) begin ew = infl.addr; ed = infl.wdata; em = infl.wmask; end
                else         er = infl.addr;
            end
            chk("ram_read_addr", bus.readAddr_o, er);
            chk("ram_write_port", {bus.writeAddr_o, bus.writeMask_o, bus.writeData_o}, {ew, em, ed});
            vld  = bus.req_valid_i;
            expr = 2'b00;
            g    = 0;
            if (!inflight && vld != 2'b00) begin
                g    = (vld == 2'b11) ? (1 - tb_last) : (vld[1] ? 1 : 0);
                expr = (g == 1) ? 2'b10 : 2'b01;
            end
            chk("req_ready", bus.req_ready_o, expr);
            if (expr != 2'b00) begin
                inflight = 1'b1; age = 0; done_age = -100;
                infl = pend[g][0]; infl_way = g; pop[g] = 1'b1; tb_last = g;
                n_acc++;
                if (vld == 2'b11) n_conf++;
            end
            if (!ram_en) begin
                bus.dataOk_i = 1'b0; bus.writeState_i = 3'd0;
            end else if (bus.readAddr_o != 32'h0) begin
                if (!ram_active) begin
                    ram_active = 1'b1; ram_cnt = 0;
                    ram_d = (force_d >= 0) ? force_d : $urandom_range(0, 7);
                end
                bus.dataOk_i     = (ram_cnt == ram_d);
                bus.readData_i   = bus.dataOk_i ? ram_word(bus.readAddr_o) : {$urandom, $urandom};
                bus.writeState_i = 3'($urandom_range(0, 7));
                if (bus.dataOk_i) done_age = age;
                ram_cnt++;
            end else if (bus.writeAddr_o != 32'h0) begin
                if (!ram_active) begin
                    ram_active = 1'b1; ram_cnt = 0;
                    ram_d = (force_d >= 0) ? force_d : $urandom_range(0, 6);
                end
                bus.writeState_i = (ram_cnt < ram_d) ? 3'd0 : (ram_cnt == ram_d) ? 3'd3 : 3'd7;
                bus.dataOk_i     = 1'($urandom);
                if (bus.writeState_i == 3'd7) done_age = age;
                ram_cnt++;
            end else begin
                ram_active = 1'b0; bus.dataOk_i = 1'b0; bus.writeState_i = 3'd0;
            end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((pend[0].size() + pend[1].size() + exp_q[0].size() + exp_q[1].size()) != 0 || inflight) begin
            @(negedge clk); #1;
            n++;
            if (n > 3000) begin chk({name, "_timeout"}, 0, 1); break; end
        end
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        bus.req_valid_i = '0; bus.req_we_i = '0; bus.req_addr_i = '0;
        bus.req_wdata_i = '0; bus.req_wmask_i = '0; bus.req_pID_i = '0;
        bus.readData_i = '0; bus.dataOk_i = 1'b0; bus.writeState_i = 3'd0;
        pop[0] = 1'b0; pop[1] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready", bus.req_ready_o, 0);
        chk("rst_resp_valid", bus.resp_valid_o, 0);
        chk("rst_resp_fields", {bus.resp_rdata_o, bus.resp_err_o, bus.resp_pID_o}, 0);
        chk("rst_ram", {bus.readAddr_o, bus.writeAddr_o, bus.writeData_o, bus.writeMask_o}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        @(posedge clk); #3;
        force_d = 3;
        push_req(0, mk_req(1'b0, 32'h8000_1000, 64'h0, 4'h0, 2'd1));
        wait_idle("dir_load");
        @(posedge clk); #3;
        force_d = 1;
        push_req(1, mk_req(1'b1, 32'h8000_2000, 64'h55, 4'b0001, 2'd2));
        wait_idle("dir_store");

        @(posedge clk); #3;
        force_d = 0;
        for (int i = 0; i < 4; i++) begin
            push_req(0, mk_req(1'($urandom), 32'h8000_4000 + 32'(i * 8), {$urandom, $urandom}, 4'($urandom), 2'(i)));
            push_req(1, mk_req(1'($urandom), 32'h8000_5000 + 32'(i * 8), {$urandom, $urandom}, 4'($urandom), 2'(3 - i)));
        end
        wait_idle("conflict");
        @(posedge clk); #3;
        push_req(0, mk_req(1'b0, 32'h0, 64'h0, 4'h0, 2'd3));
        wait_idle("timeout");

        force_d = -1;
        gen_en  = 1'b1;
        repeat (600) @(posedge clk);
        gen_en  = 1'b0;
        wait_idle("random");

`ifdef MEM_ARB_PERF_EN
        chk("perf_accesses", perf_acc, n_acc);
        chk("perf_conflicts", perf_conf, n_conf);
        chk("perf_timeouts", perf_tmo, n_tmo);
`endif

        ram_en = 1'b0;
        @(posedge clk); #3;
        push_req(0, mk_req(1'b0, 32'h8000_3000, 64'h0, 4'h0, 2'd2));
        n = 0;
        while (!(inflight && age >= 2) && n < 50) begin @(negedge clk); #1; n++; end
        chk("midrst_inflight", 160'(inflight && age >= 2), 1);
        #1;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        pend[0].delete(); pend[1].delete(); exp_q[0].delete(); exp_q[1].delete();
        inflight = 1'b0; pop[0] = 1'b0; pop[1] = 1'b0;
        drive_inputs();
        #1;
        chk("midrst_resp_valid", bus.resp_valid_o, 0);
        chk("midrst_ram", {bus.readAddr_o, bus.writeAddr_o, bus.writeData_o, bus.writeMask_o}, 0);
        chk("midrst_resp_fields", {bus.resp_rdata_o, bus.resp_err_o, bus.resp_pID_o}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        bus.dataOk_i = 1'b1; bus.readData_i = 64'hFFFF_0000_FFFF_0000; bus.writeState_i = 3'd7;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_resp", bus.resp_valid_o, 0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-RAM port between the way0 and way1 memory-access units of the dual-issue core.
- Accepts one load or store at a time and drives the RAM read/write address, data and mask.
- Waits for dataOk_i on loads or writeState_i == 3'b111 on stores, then returns a registered response to the granting way.
- Sits between the per-way memory units and the RAM.

Parameters:
- TIMEOUT_CYCLES, 255: max wait cycles for RAM completion before an error response; must be >= 1.
- NUM_WAYS, 2: requester count; fixed at 2, arbitration logic assumes exactly 2.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- req_valid_i  in  2  per-way request valid, bit0 = way0
- req_we_i  in  2  per-way 1 = store, 0 = load
- req_addr_i  in  2x32  per-way byte address
- req_wdata_i  in  2x64  per-way store data
- req_wmask_i  in  2x4  per-way store mask
- req_pID_i  in  2x2  per-way pipeline ID
- req_ready_o  out  2  per-way request accepted this cycle
- resp_valid_o  out  2  per-way one-cycle response pulse
- resp_rdata_o  out  64  raw load data, shared by both ways
- resp_err_o  out  1  response was a timeout
- resp_pID_o  out  2  pID of the completed request
- readAddr_o  out  32  RAM read address (0 = no read)
- writeAddr_o  out  32  RAM write address (0 = no write)
- writeData_o  out  64  RAM write data
- writeMask_o  out  4  RAM write mask
- readData_i  in  64  RAM read data
- dataOk_i  in  1  RAM read complete
- writeState_i  in  3  RAM write progress; 3'b111 = write complete

Behaviour:
- Clock and reset:
  - Single clock clk.
  - reset_n is asynchronous, active-low.
- Reset values:
  - state = IDLE, last_grant = 1 (way0 wins first tie).
  - All RAM outputs 0.
  - req_ready_o = 0, resp_valid_o = 0, resp_rdata_o = 0, resp_err_o = 0, resp_pID_o = 0.
  - Timeout counter = 0.
- States:
  - IDLE: no access in flight.
  - RD_WAIT: load issued, waiting for dataOk_i.
  - WR_WAIT: store issued, waiting for writeState_i == 3'b111.
- Arbitration (IDLE only, combinational):
  - One valid requester: that way is granted.
  - Both valid: grant ~last_grant (round-robin).
  - req_ready_o[g] = 1 for the granted way only; the other bit stays 0.
- Accept edge:
  - Latch addr, wdata, wmask, pID, we and the grant index g.
  - last_grant <= g; counter <= 0.
  - Next state: WR_WAIT if we, else RD_WAIT.
- RAM outputs (registered, from latched fields):
  - Valid from the cycle after accept.
  - RD_WAIT drives readAddr_o only; WR_WAIT drives writeAddr_o, writeData_o and writeMask_o.
  - Every unused RAM output is 0; all RAM outputs are 0 in IDLE.
- Completion:
  - RD_WAIT with dataOk_i, or WR_WAIT with writeState_i == 3'b111:
    - Next edge: state -> IDLE; resp_valid_o[g] pulses for 1 cycle; resp_pID_o = latched pID; resp_err_o = 0.
    - resp_rdata_o = readData_i captured on loads; stores return 0.
  - Latency: accept at N, RAM address at N+1, completion seen at M, response at M+1.
  - A new accept is allowed in the response cycle (back-to-back).
- Timeout:
  - Counter increments every wait cycle without completion.
  - Reaching TIMEOUT_CYCLES-1 with no completion: next edge -> IDLE, resp_valid_o[g] = 1, resp_err_o = 1, resp_rdata_o = 0.
  - Completion arriving in the same cycle as the last count: treated as success.
- Stray RAM events:
  - dataOk_i in IDLE or WR_WAIT is ignored.
  - writeState_i == 3'b111 in IDLE or RD_WAIT is ignored.
- Requester rules:
  - Requesters hold request fields stable until req_ready_o; the arbiter never drops a held request.
  - A request with address 0 is accepted normally; RAM sees 0 = no access, so it completes only by timeout.
- Reset mid-operation: the in-flight access is abandoned; no response is issued.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Enabled:
  - Adds outputs perf_accesses_o (32), perf_conflicts_o (32), perf_timeouts_o (16).
  - Each is a saturating counter, cleared by reset.
  - perf_accesses_o increments on each accept; perf_conflicts_o on each accept where both ways are valid; perf_timeouts_o on each timeout response.
- Disabled: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef arb_state_e {IDLE, RD_WAIT, WR_WAIT};
  - typedef mem_req_t {we, addr, wdata, wmask, pID};
  - constant WRITE_DONE = 3'b111.
- One sub-module, rr_arbiter2: 2-input round-robin grant with last_grant state.

Test Plan:
- Way0 load, addr 0x80001000; dataOk_i 3 cycles after issue, readData_i = 0xDEADBEEF_12345678 -> readAddr_o = 0x80001000 from N+1; resp_valid_o = 2'b01 one cycle after dataOk_i; resp_rdata_o matches.
- Way1 store, addr 0x80002000, wdata 0x55, mask 4'b0001; writeState_i steps 0 -> 3 -> 7 -> writeAddr_o, writeData_o, writeMask_o held until 7; resp_valid_o = 2'b10; readAddr_o stays 0.
- Both ways valid every cycle from reset, RAM completing immediately -> grants alternate way0, way1, way0, way1; no lost request; pIDs returned in order.
- TIMEOUT_CYCLES = 8, load with no dataOk_i -> resp_valid_o with resp_err_o = 1 after 8 wait cycles; state IDLE; the next request is accepted.
- reset_n asserted low during RD_WAIT, then a late dataOk_i -> all outputs 0 immediately; no resp_valid_o after reset release.
- With MEM_ARB_PERF_EN: 4 conflicting accesses plus 1 timeout -> perf_accesses_o = 5, perf_conflicts_o = 4, perf_timeouts_o = 1.
